// File: rtl/spi_txmem_loader.sv
// Port-A writer for the SPI transmit memory: formats it with FILL_PATTERN after Reset or on request,
// and packs a valid/ready byte stream into 32-bit words. Define TXLOAD_CHECKSUM_EN to add o_checksum.
module spi_txmem_loader #(
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] FILL_PATTERN = 32'h5A6C_C6A5
) (
    input  logic              SysClk,
    input  logic              Reset,
    input  logic              i_start_fill,
    input  logic              i_start_stream,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_abort,
    input  logic [7:0]        i_byte_data,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_busy,
    output logic              o_fill_done,
    output logic              o_stream_done
`ifdef TXLOAD_CHECKSUM_EN
   ,output logic [7:0]        o_checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   ONE_WORD  = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM} state_t;

    state_t            r_state,     w_state;
    logic              r_memWe,     w_memWe;
    logic [ADDR_W-1:0] r_memAddr,   w_memAddr;
    logic [31:0]       r_memData,   w_memData;
    logic              r_byteReady, w_byteReady;
    logic              r_busy,      w_busy;
    logic              r_fillDone,  w_fillDone;
    logic              r_streamDone, w_streamDone;
    logic [1:0]        r_lane,      w_lane;
    logic [ADDR_W:0]   r_wordCnt,   w_wordCnt;
    logic [ADDR_W-1:0] r_wordAddr,  w_wordAddr;
    logic [23:0]       r_held,      w_held;
    logic              w_accept;
`ifdef TXLOAD_CHECKSUM_EN
    logic [7:0]        r_checksum,  w_checksum;
`endif

    assign w_accept = i_byte_valid && r_byteReady;

    always_comb begin
        w_state      = r_state;
        w_memWe      = 1'b0;
        w_memAddr    = r_memAddr;
        w_memData    = r_memData;
        w_byteReady  = r_byteReady;
        w_busy       = r_busy;
        w_fillDone   = 1'b0;
        w_streamDone = 1'b0;
        w_lane       = r_lane;
        w_wordCnt    = r_wordCnt;
        w_wordAddr   = r_wordAddr;
        w_held       = r_held;
`ifdef TXLOAD_CHECKSUM_EN
        w_checksum   = r_checksum;
`endif
        if (i_abort) begin
            // Abort also kills a write whose 4th byte is handshaking this very cycle.
            w_state     = ST_IDLE;
            w_byteReady = 1'b0;
            w_busy      = 1'b0;
            w_lane      = 2'd0;
            w_held      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start_fill) begin
                        w_state   = ST_FILL;
                        w_memWe   = 1'b1;
                        w_memAddr = '0;
                        w_memData = FILL_PATTERN;
                        w_busy    = 1'b1;
                    end else if (i_start_stream) begin
`ifdef TXLOAD_CHECKSUM_EN
                        w_checksum = 8'h00;
`endif
                        if (i_word_count == '0) begin
                            w_streamDone = 1'b1;
                        end else begin
                            w_state     = ST_STREAM;
                            w_byteReady = 1'b1;
                            w_busy      = 1'b1;
                            w_wordAddr  = i_start_addr;
                            w_wordCnt   = i_word_count;
                            w_lane      = 2'd0;
                            w_held      = '0;
                        end
                    end
                end
                ST_FILL: begin
                    // r_memWe low only on the first cycle out of Reset, before any write.
                    w_memData = FILL_PATTERN;
                    if (!r_memWe) begin
                        w_memWe   = 1'b1;
                        w_memAddr = '0;
                    end else if (r_memAddr == LAST_ADDR) begin
                        w_fillDone = 1'b1;
                        w_busy     = 1'b0;
                        w_state    = ST_IDLE;
                    end else begin
                        w_memWe   = 1'b1;
                        w_memAddr = r_memAddr + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
`ifdef TXLOAD_CHECKSUM_EN
                        w_checksum = r_checksum + i_byte_data;
`endif
                        case (r_lane)
                            2'd0: w_held[7:0]   = i_byte_data;
                            2'd1: w_held[15:8]  = i_byte_data;
                            2'd2: w_held[23:16] = i_byte_data;
                            default: begin
                                w_memWe    = 1'b1;
                                w_memAddr  = r_wordAddr;
                                w_memData  = {i_byte_data, r_held};
                                w_wordAddr = r_wordAddr + 1'b1;
                                w_wordCnt  = r_wordCnt - ONE_WORD;
                                if (r_wordCnt == ONE_WORD) begin
                                    w_byteReady  = 1'b0;
                                    w_streamDone = 1'b1;
                                    w_busy       = 1'b0;
                                    w_state      = ST_IDLE;
                                end
                            end
                        endcase
                        w_lane = r_lane + 2'd1;
                    end
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_state      <= ST_FILL;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memData    <= FILL_PATTERN;
            r_byteReady  <= 1'b0;
            r_busy       <= 1'b1;
            r_fillDone   <= 1'b0;
            r_streamDone <= 1'b0;
            r_lane       <= 2'd0;
            r_wordCnt    <= '0;
            r_wordAddr   <= '0;
            r_held       <= '0;
`ifdef TXLOAD_CHECKSUM_EN
            r_checksum   <= 8'h00;
`endif
        end else begin
            r_state      <= w_state;
            r_memWe      <= w_memWe;
            r_memAddr    <= w_memAddr;
            r_memData    <= w_memData;
            r_byteReady  <= w_byteReady;
            r_busy       <= w_busy;
            r_fillDone   <= w_fillDone;
            r_streamDone <= w_streamDone;
            r_lane       <= w_lane;
            r_wordCnt    <= w_wordCnt;
            r_wordAddr   <= w_wordAddr;
            r_held       <= w_held;
`ifdef TXLOAD_CHECKSUM_EN
            r_checksum   <= w_checksum;
`endif
        end
    end

    assign o_byte_ready  = r_byteReady;
    assign o_mem_we      = r_memWe;
    assign o_mem_addr    = r_memAddr;
    assign o_mem_data    = r_memData;
    assign o_busy        = r_busy;
    assign o_fill_done   = r_fillDone;
    assign o_stream_done = r_streamDone;
`ifdef TXLOAD_CHECKSUM_EN
    assign o_checksum    = r_checksum;
`endif

endmodule

// File: tb/tb_spi_txmem_loader.sv
// Bench for spi_txmem_loader: fixed stream vectors, hand-written fill/abort/reset sequences,
// and randomized streams checked against a packing model. Honours TXLOAD_CHECKSUM_EN.
module tb_spi_txmem_loader;

    localparam int          DEPTH   = 1024;
    localparam logic [31:0] PATTERN = 32'h5A6C_C6A5;

    logic        SysClk = 1'b0;
    logic        Reset = 1'b1;
    logic        i_start_fill = 1'b0, i_start_stream = 1'b0, i_abort = 1'b0, i_byte_valid = 1'b0;
    logic [9:0]  i_start_addr = '0;
    logic [10:0] i_word_count = '0;
    logic [7:0]  i_byte_data = '0;
    logic        o_byte_ready, o_mem_we, o_busy, o_fill_done, o_stream_done;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_data;
`ifdef TXLOAD_CHECKSUM_EN
    logic [7:0]  o_checksum;
`endif

    spi_txmem_loader dut (
        .SysClk(SysClk), .Reset(Reset),
        .i_start_fill(i_start_fill), .i_start_stream(i_start_stream),
        .i_start_addr(i_start_addr), .i_word_count(i_word_count), .i_abort(i_abort),
        .i_byte_data(i_byte_data), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
        .o_busy(o_busy), .o_fill_done(o_fill_done), .o_stream_done(o_stream_done)
`ifdef TXLOAD_CHECKSUM_EN
       ,.o_checksum(o_checksum)
`endif
    );

    always #5 SysClk = ~SysClk;

    int cyc = 0;
    always @(posedge SysClk) cyc <= cyc + 1;

    int totalCount = 0;
    int badCount = 0;

    // Write/done log; sampled mid-cycle so each registered output cycle is seen once.
    logic [9:0]  wrAddrQ[$];
    logic [31:0] wrDataQ[$];
    int          wrCycQ[$];
    int          doneCycQ[$];
    int          fillDoneCycQ[$];
    int          hsCycQ[$];
    logic [7:0]  streamBytes[$];
    logic [9:0]  expAddrQ[$];
    logic [31:0] expDataQ[$];

    always @(negedge SysClk) begin
        if (o_mem_we) begin
            wrAddrQ.push_back(o_mem_addr);
            wrDataQ.push_back(o_mem_data);
            wrCycQ.push_back(cyc);
        end
        if (o_stream_done) doneCycQ.push_back(cyc);
        if (o_fill_done) fillDoneCycQ.push_back(cyc);
    end

    typedef struct {
        string       name;
        logic [9:0]  startAddr;
        logic [10:0] wordCount;
        logic [63:0] bytesLe;
        bit          gapped;
        logic [9:0]  expAddr0;
        logic [31:0] expData0;
        logic [9:0]  expAddr1;
        logic [31:0] expData1;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge SysClk);
        #1;
    endtask

    task automatic clearLogs();
        wrAddrQ.delete(); wrDataQ.delete(); wrCycQ.delete();
        doneCycQ.delete(); fillDoneCycQ.delete(); hsCycQ.delete();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic waitFillDone(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fillDoneCycQ.size() != 0) break;
            tick();
        end
        checkOutput("fill_done_seen", 32'(fillDoneCycQ.size()), 32'd1);
        tick();
        tick();
    endtask

    task automatic checkFill(input string name, input int firstCyc);
        int errs;
        errs = 0;
        checkOutput({name, "_count"}, 32'(wrAddrQ.size()), 32'd1024);
        for (int i = 0; i < wrAddrQ.size(); i++)
            if (wrAddrQ[i] !== 10'(i) || wrDataQ[i] !== PATTERN || wrCycQ[i] != firstCyc + i) errs++;
        checkOutput({name, "_content"}, 32'(errs), 32'd0);
        checkOutput({name, "_done_cyc"}, fillDoneCycQ.size() > 0 ? 32'(fillDoneCycQ[0]) : 32'hFFFF_FFFF,
                    32'(firstCyc + DEPTH));
        checkOutput({name, "_done_pulses"}, 32'(fillDoneCycQ.size()), 32'd1);
        checkOutput({name, "_busy_after"}, 32'(o_busy), 32'd0);
        checkOutput({name, "_no_stream_done"}, 32'(doneCycQ.size()), 32'd0);
        checkOutput({name, "_ready_low"}, 32'(o_byte_ready), 32'd0);
    endtask

    // Feeds streamBytes; gapMode 0 = continuous, 1 = valid every other cycle, 2 = random valid.
    task automatic applyStimulus(input string name, input logic [9:0] sa, input logic [10:0] wc,
                                 input int gapMode, input int budget);
        int idx;
        bit phase;
        idx = 0;
        phase = 1'b1;
        i_start_addr = sa;
        i_word_count = wc;
        i_start_stream = 1'b1;
        tick();
        i_start_stream = 1'b0;
        for (int b = 0; b < budget && idx < streamBytes.size(); b++) begin
            case (gapMode)
                0:       i_byte_valid = 1'b1;
                1:       i_byte_valid = phase;
                default: i_byte_valid = ($urandom_range(0, 2) != 0);
            endcase
            phase = ~phase;
            i_byte_data = i_byte_valid ? streamBytes[idx] : 8'($urandom);
            if (i_byte_valid && o_byte_ready) begin
                hsCycQ.push_back(cyc + 1);
                idx++;
            end
            tick();
        end
        i_byte_valid = 1'b0;
        checkOutput({name, "_bytes_accepted"}, 32'(idx), 32'(streamBytes.size()));
        tick(); tick(); tick();
    endtask

    task automatic modelStream(input logic [9:0] sa);
        expAddrQ.delete();
        expDataQ.delete();
        for (int w = 0; w < streamBytes.size() / 4; w++) begin
            expAddrQ.push_back(10'(int'(sa) + w));
            expDataQ.push_back({streamBytes[4*w+3], streamBytes[4*w+2], streamBytes[4*w+1], streamBytes[4*w]});
        end
    endtask

    task automatic checkStream(input string name);
        int nWords, errs, terrs;
        nWords = expAddrQ.size();
        errs = 0;
        terrs = 0;
        checkOutput({name, "_write_count"}, 32'(wrAddrQ.size()), 32'(nWords));
        for (int i = 0; i < nWords && i < wrAddrQ.size(); i++) begin
            if (nWords <= 4) begin
                checkOutput({name, "_addr"}, 32'(wrAddrQ[i]), 32'(expAddrQ[i]));
                checkOutput({name, "_data"}, wrDataQ[i], expDataQ[i]);
            end else if (wrAddrQ[i] !== expAddrQ[i] || wrDataQ[i] !== expDataQ[i]) begin
                errs++;
            end
            if (4*i+3 < hsCycQ.size() && wrCycQ[i] != hsCycQ[4*i+3]) terrs++;
        end
        if (nWords > 4) checkOutput({name, "_word_errors"}, 32'(errs), 32'd0);
        checkOutput({name, "_write_timing_errors"}, 32'(terrs), 32'd0);
        checkOutput({name, "_done_pulses"}, 32'(doneCycQ.size()), 32'd1);
        checkOutput({name, "_done_cyc"}, doneCycQ.size() > 0 ? 32'(doneCycQ[0]) : 32'hFFFF_FFFF,
                    hsCycQ.size() > 0 ? 32'(hsCycQ[hsCycQ.size()-1]) : 32'hFFFF_FFFE);
        checkOutput({name, "_ready_low"}, 32'(o_byte_ready), 32'd0);
        checkOutput({name, "_busy_low"}, 32'(o_busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_we"}, 32'(o_mem_we), 32'd0);
        checkOutput({name, "_addr"}, 32'(o_mem_addr), 32'd0);
        checkOutput({name, "_data"}, o_mem_data, PATTERN);
        checkOutput({name, "_ready"}, 32'(o_byte_ready), 32'd0);
        checkOutput({name, "_busy"}, 32'(o_busy), 32'd1);
        checkOutput({name, "_dones"}, {30'd0, o_fill_done, o_stream_done}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int firstCyc;
        logic [9:0] sa;
        int wc;

        vecs[0] = '{"wrap",   10'h3FF, 11'd2, 64'h8877_6655_4433_2211, 1'b0, 10'h3FF, 32'h4433_2211, 10'h000, 32'h8877_6655};
        vecs[1] = '{"gapped", 10'h3FF, 11'd2, 64'h8877_6655_4433_2211, 1'b1, 10'h3FF, 32'h4433_2211, 10'h000, 32'h8877_6655};
        vecs[2] = '{"single", 10'h123, 11'd1, 64'h0000_0000_D3C2_B1A0, 1'b0, 10'h123, 32'hD3C2_B1A0, 10'h000, 32'h0};
        vecs[3] = '{"mid",    10'h010, 11'd2, 64'h0807_0605_0403_0201, 1'b1, 10'h010, 32'h0403_0201, 10'h011, 32'h0807_0605};

        // Reset and the power-on fill.
        tick();
        tick();
        checkResetOutputs("reset");
        clearLogs();
        firstCyc = cyc + 1;
        Reset = 1'b0;
        waitFillDone(1100);
        checkFill("fill_reset", firstCyc);

        // Fixed vectors.
        for (int v = 0; v < 4; v++) begin
            clearLogs();
            streamBytes.delete();
            for (int b = 0; b < 4 * int'(vecs[v].wordCount); b++) streamBytes.push_back(vecs[v].bytesLe[8*b +: 8]);
            expAddrQ.delete();
            expDataQ.delete();
            expAddrQ.push_back(vecs[v].expAddr0);
            expDataQ.push_back(vecs[v].expData0);
            if (vecs[v].wordCount == 11'd2) begin
                expAddrQ.push_back(vecs[v].expAddr1);
                expDataQ.push_back(vecs[v].expData1);
            end
            applyStimulus(vecs[v].name, vecs[v].startAddr, vecs[v].wordCount, vecs[v].gapped ? 1 : 0, 100);
            checkStream(vecs[v].name);
        end

        // word_count = 0: done next cycle, no write.
        clearLogs();
        i_word_count = 11'd0;
        i_start_stream = 1'b1;
        tick();
        i_start_stream = 1'b0;
        checkOutput("zero_done", 32'(o_stream_done), 32'd1);
        checkOutput("zero_busy", 32'(o_busy), 32'd0);
        checkOutput("zero_ready", 32'(o_byte_ready), 32'd0);
        tick(); tick();
        checkOutput("zero_writes", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("zero_done_pulses", 32'(doneCycQ.size()), 32'd1);

        // Abort after 2 bytes of a 1-word stream, then a clean stream from lane 0.
        clearLogs();
        i_start_addr = 10'h050;
        i_word_count = 11'd1;
        i_start_stream = 1'b1;
        tick();
        i_start_stream = 1'b0;
        i_byte_valid = 1'b1; i_byte_data = 8'hAA; tick();
        i_byte_data = 8'hBB; tick();
        i_byte_valid = 1'b0; i_abort = 1'b1; tick();
        i_abort = 1'b0;
        checkOutput("abort_ready", 32'(o_byte_ready), 32'd0);
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        tick(); tick();
        checkOutput("abort_writes", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("abort_done", 32'(doneCycQ.size()), 32'd0);
        clearLogs();
        streamBytes = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        expAddrQ = '{10'h051};
        expDataQ = '{32'hF0DE_BC9A};
        applyStimulus("after_abort", 10'h051, 11'd1, 0, 50);
        checkStream("after_abort");

        // Abort coinciding with the 4th byte handshake suppresses the write.
        clearLogs();
        i_start_addr = 10'h060;
        i_word_count = 11'd1;
        i_start_stream = 1'b1;
        tick();
        i_start_stream = 1'b0;
        i_byte_valid = 1'b1;
        i_byte_data = 8'h11; tick();
        i_byte_data = 8'h22; tick();
        i_byte_data = 8'h33; tick();
        i_byte_data = 8'h44; i_abort = 1'b1; tick();
        i_byte_valid = 1'b0; i_abort = 1'b0;
        checkOutput("abort4_we", 32'(o_mem_we), 32'd0);
        tick(); tick();
        checkOutput("abort4_writes", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("abort4_done", 32'(doneCycQ.size()), 32'd0);

        // Simultaneous starts: fill wins; starts during the fill are ignored.
        clearLogs();
        firstCyc = cyc + 1;
        i_start_fill = 1'b1;
        i_start_stream = 1'b1;
        i_word_count = 11'd1;
        tick();
        i_start_fill = 1'b0;
        i_start_stream = 1'b0;
        repeat (10) tick();
        i_start_stream = 1'b1; tick(); i_start_stream = 1'b0;
        repeat (10) tick();
        i_start_fill = 1'b1; tick(); i_start_fill = 1'b0;
        waitFillDone(1100);
        checkFill("fill_cmd", firstCyc);

        // Reset mid-stream after 5 bytes, then the full fill ignores a start_stream.
        clearLogs();
        i_start_addr = 10'h200;
        i_word_count = 11'd2;
        i_start_stream = 1'b1;
        tick();
        i_start_stream = 1'b0;
        i_byte_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            i_byte_data = 8'(8'h30 + b);
            tick();
        end
        i_byte_valid = 1'b0;
        Reset = 1'b1;
        tick();
        checkResetOutputs("midreset");
        clearLogs();
        firstCyc = cyc + 1;
        Reset = 1'b0;
        repeat (20) tick();
        i_start_stream = 1'b1; tick(); i_start_stream = 1'b0;
        waitFillDone(1100);
        checkFill("fill_midreset", firstCyc);

        // Randomized short streams against the packing model.
        for (int t = 0; t < 6; t++) begin
            clearLogs();
            sa = 10'($urandom_range(0, DEPTH - 1));
            wc = $urandom_range(1, 6);
            streamBytes.delete();
            for (int b = 0; b < 4 * wc; b++) streamBytes.push_back(8'($urandom));
            modelStream(sa);
            applyStimulus("rand", sa, 11'(wc), 2, 16 * wc + 20);
            checkStream("rand");
        end

        // Full-memory stream from a random start address.
        clearLogs();
        sa = 10'($urandom_range(1, DEPTH - 1));
        streamBytes.delete();
        for (int b = 0; b < 4 * DEPTH; b++) streamBytes.push_back(8'($urandom));
        modelStream(sa);
        applyStimulus("full", sa, 11'd1024, 0, 4 * DEPTH + 20);
        checkStream("full");

`ifdef TXLOAD_CHECKSUM_EN
        clearLogs();
        streamBytes = '{8'hFF, 8'h01, 8'h10, 8'h20};
        expAddrQ = '{10'h300};
        expDataQ = '{32'h2010_01FF};
        applyStimulus("csum", 10'h300, 11'd1, 0, 50);
        checkStream("csum");
        checkOutput("csum_value", 32'(o_checksum), 32'h30);
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
